lzw_stream_encoder: RTL and testbench
=====================================

LZW_STREAM_ENCODER -- requirements
Module: lzw_stream_encoder

Interface
REQ-001 SHALL expose parameter DATA_WIDTH, default 8, symbol width in bits.
REQ-002 SHALL expose parameter CODE_WIDTH, default 12, output code width in bits.
REQ-003 SHALL expose parameter DICT_DEPTH, default 64, number of learned dictionary entries; DICT_DEPTH <= 2^CODE_WIDTH - 2^DATA_WIDTH - 1.
REQ-004 SHALL expose parameter FULL_MODE, default 0; 0 = freeze dictionary when full, 1 = emit CLEAR and restart dictionary.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 cs  input  1  chip select; sampled only in IDLE.
REQ-009 in_valid  input  1  input symbol valid.
REQ-010 in_ready  output  1  encoder accepts symbol.
REQ-011 in_data  input  DATA_WIDTH  input symbol.
REQ-012 in_last  input  1  final symbol of stream.
REQ-013 out_valid  output  1  code valid.
REQ-014 out_ready  input  1  downstream accepts code.
REQ-015 out_code  output  CODE_WIDTH  emitted code.
REQ-016 out_last  output  1  final code of stream.
REQ-017 busy  output  1  high in any state except IDLE.
REQ-018 dict_count  output  clog2(DICT_DEPTH+1)  learned entries currently valid.

Function
REQ-019 Codes: literal = zero-extended symbol; CLEAR = 2^DATA_WIDTH; entry i = 2^DATA_WIDTH+1+i.
REQ-020 Entry storage: (prefix code, symbol) pairs in a register array, written at index dict_count.
REQ-021 States: IDLE, FIRST, WAIT_IN, SEARCH, EMIT, EMIT_CLR, EMIT_LAST.
REQ-022 IDLE: in_ready=0; cs=1 -> FIRST, dict_count<=0.
REQ-023 FIRST: in_ready=1; on accept w<=symbol; in_last=1 -> EMIT_LAST, else WAIT_IN.
REQ-024 WAIT_IN: in_ready=1; on accept latch c and in_last, idx<=0 -> SEARCH.
REQ-025 SEARCH: compares entry idx to (w,c) one entry per cycle; hit -> w<=entry code; miss when idx==dict_count.
REQ-026 SEARCH latency: hit at idx k resolves in k+1 cycles; miss in dict_count+1 cycles.
REQ-027 On hit: latched in_last=1 -> EMIT_LAST, else WAIT_IN.
REQ-028 On miss: out_code<=w -> EMIT; entry (w,c) written at dict_count and dict_count incremented if dict_count<DICT_DEPTH; w<=c.
REQ-029 EMIT: out_valid=1, out_code stable until out_ready; on handshake -> EMIT_CLR if FULL_MODE=1 and dict_count==DICT_DEPTH, else latched in_last ? EMIT_LAST : WAIT_IN.
REQ-030 EMIT_CLR: out_code=CLEAR; on handshake dict_count<=0, then latched in_last ? EMIT_LAST : WAIT_IN.
REQ-031 EMIT_LAST: out_code=w, out_last=1; on handshake -> IDLE.
REQ-032 FULL_MODE=0 at full: no write, dict_count holds DICT_DEPTH, searches continue over frozen entries.
REQ-033 in_ready and out_valid never both high; at most one symbol accepted per cycle.
REQ-034 cs deassertion outside IDLE ignored; stream always completes through EMIT_LAST.
REQ-035 Single-symbol stream (in_last on first symbol) emits exactly one code with out_last=1.

Reset
REQ-036 rst=1 at any edge: state<=IDLE, in_ready=0, out_valid=0, out_last=0, out_code=0, busy=0, dict_count=0, w=0; mid-stream reset drops pending codes.
REQ-037 Dictionary contents need not clear; dict_count=0 invalidates all entries.

Verification (DATA_WIDTH=8, CODE_WIDTH=12)
REQ-038 DICT_DEPTH=4, out_ready=1, "ABABABA" (0x41/0x42) -> codes 0x041,0x042,0x101,0x103(out_last), dict_count=3.
REQ-039 DICT_DEPTH=2, FULL_MODE=1, "ABCD" -> 0x041,0x042,0x100,0x043,0x044(last); dict_count=1 at end.
REQ-040 DICT_DEPTH=2, FULL_MODE=0, "ABCD" -> 0x041,0x042,0x043,0x044(last); dict_count saturates at 2.
REQ-041 Single symbol 0x7F with in_last -> one code 0x07F, out_last=1, then busy=0.
REQ-042 Case REQ-038 with out_ready low 5 cycles per code -> identical code sequence, out_code stable while stalled.
REQ-043 rst pulsed after 3 symbols accepted -> outputs at reset values next cycle; new stream "AB" -> 0x041,0x042(last).

Source files
------------

// File: rtl/lzw_stream_encoder.sv
// rtl/lzw_stream_encoder.sv - streaming LZW encoder with a linear-search register dictionary
module lzw_stream_encoder #(
    parameter int DATA_WIDTH = 8,
    parameter int CODE_WIDTH = 12,
    parameter int DICT_DEPTH = 64,
    parameter int FULL_MODE  = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cs,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [CODE_WIDTH-1:0]             out_code,
    output logic                              out_last,
    output logic                              busy,
    output logic [$clog2(DICT_DEPTH+1)-1:0]   dict_count
);
    localparam int CNT_W = $clog2(DICT_DEPTH + 1);
    localparam int IDX_W = (DICT_DEPTH > 1) ? $clog2(DICT_DEPTH) : 1;
    localparam logic [CODE_WIDTH-1:0] CLEAR_CODE = CODE_WIDTH'(2 ** DATA_WIDTH);
    localparam logic [CODE_WIDTH-1:0] ENTRY_BASE = CODE_WIDTH'(2 ** DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]      DEPTH_CNT  = CNT_W'(DICT_DEPTH);

    typedef enum logic [2:0] {
        IDLE, FIRST, WAIT_IN, SEARCH, EMIT, EMIT_CLR, EMIT_LAST
    } state_t;

    state_t                 state;
    logic [CODE_WIDTH-1:0]  w;
    logic [DATA_WIDTH-1:0]  c;
    logic                   last_q;
    logic [CNT_W-1:0]       idx;

    logic [CODE_WIDTH-1:0]  dict_prefix [DICT_DEPTH];
    logic [DATA_WIDTH-1:0]  dict_sym    [DICT_DEPTH];

    logic [IDX_W-1:0]       rd_idx;
    logic [IDX_W-1:0]       wr_idx;
    logic                   entry_hit;
    logic                   search_miss;
    logic                   dict_we;
    logic [CODE_WIDTH-1:0]  entry_code;
    logic [CODE_WIDTH-1:0]  c_code;
    logic [CODE_WIDTH-1:0]  in_code;

    // idx can equal dict_count (== DICT_DEPTH when frozen); the miss test wins before the truncated read matters
    assign rd_idx      = idx[IDX_W-1:0];
    assign wr_idx      = dict_count[IDX_W-1:0];
    assign search_miss = (idx == dict_count);
    assign entry_hit   = (dict_prefix[rd_idx] == w) && (dict_sym[rd_idx] == c);
    assign entry_code  = ENTRY_BASE + CODE_WIDTH'(idx);
    assign c_code      = {{(CODE_WIDTH-DATA_WIDTH){1'b0}}, c};
    assign in_code     = {{(CODE_WIDTH-DATA_WIDTH){1'b0}}, in_data};
    assign dict_we     = (state == SEARCH) && search_miss && (dict_count < DEPTH_CNT);

    // Dictionary storage: learned (prefix, symbol) pair lands at index dict_count on a miss
    always_ff @(posedge clk) begin
        if (dict_we) begin
            dict_prefix[wr_idx] <= w;
            dict_sym[wr_idx]    <= c;
        end
    end

    // Control FSM; every output is registered alongside the state it belongs to
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_code   <= '0;
            busy       <= 1'b0;
            dict_count <= '0;
            w          <= '0;
            c          <= '0;
            last_q     <= 1'b0;
            idx        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs) begin
                        state      <= FIRST;
                        dict_count <= '0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                FIRST: begin
                    if (in_valid) begin
                        w <= in_code;
                        if (in_last) begin
                            state     <= EMIT_LAST;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_last  <= 1'b1;
                            out_code  <= in_code;
                        end else begin
                            state <= WAIT_IN;
                        end
                    end
                end
                WAIT_IN: begin
                    if (in_valid) begin
                        c        <= in_data;
                        last_q   <= in_last;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (search_miss) begin
                        out_code  <= w;
                        out_valid <= 1'b1;
                        w         <= c_code;
                        state     <= EMIT;
                        if (dict_count < DEPTH_CNT) begin
                            dict_count <= dict_count + 1'b1;
                        end
                    end else if (entry_hit) begin
                        w <= entry_code;
                        if (last_q) begin
                            state     <= EMIT_LAST;
                            out_valid <= 1'b1;
                            out_last  <= 1'b1;
                            out_code  <= entry_code;
                        end else begin
                            state    <= WAIT_IN;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if ((FULL_MODE == 1) && (dict_count == DEPTH_CNT)) begin
                            state    <= EMIT_CLR;
                            out_code <= CLEAR_CODE;
                        end else if (last_q) begin
                            state    <= EMIT_LAST;
                            out_code <= w;
                            out_last <= 1'b1;
                        end else begin
                            state     <= WAIT_IN;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                        end
                    end
                end
                EMIT_CLR: begin
                    if (out_ready) begin
                        dict_count <= '0;
                        if (last_q) begin
                            state    <= EMIT_LAST;
                            out_code <= w;
                            out_last <= 1'b1;
                        end else begin
                            state     <= WAIT_IN;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                        end
                    end
                end
                EMIT_LAST: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lzw_stream_encoder.sv
// tb/tb_lzw_stream_encoder.sv - randomized model-checked bench for lzw_stream_encoder
module tb_lzw_stream_encoder;
    localparam int DW = 8;
    localparam int CW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst       [3];
    logic          cs        [3];
    logic          in_valid  [3];
    logic          in_ready  [3];
    logic [DW-1:0] in_data   [3];
    logic          in_last   [3];
    logic          out_valid [3];
    logic          out_ready [3];
    logic [CW-1:0] out_code  [3];
    logic          out_last  [3];
    logic          busy      [3];
    logic [2:0]    dc0;
    logic [1:0]    dc1;
    logic [1:0]    dc2;

    int n_checks = 0;
    int n_fail   = 0;

    int stim  [$];
    int exp_c [$];
    int exp_n;
    int got_c [$];
    int got_l [$];
    int lit   [$];

    lzw_stream_encoder #(.DATA_WIDTH(DW), .CODE_WIDTH(CW), .DICT_DEPTH(4), .FULL_MODE(0)) u0 (
        .clk(clk), .rst(rst[0]), .cs(cs[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_last(in_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_code(out_code[0]), .out_last(out_last[0]), .busy(busy[0]), .dict_count(dc0)
    );
    lzw_stream_encoder #(.DATA_WIDTH(DW), .CODE_WIDTH(CW), .DICT_DEPTH(2), .FULL_MODE(1)) u1 (
        .clk(clk), .rst(rst[1]), .cs(cs[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_last(in_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_code(out_code[1]), .out_last(out_last[1]), .busy(busy[1]), .dict_count(dc1)
    );
    lzw_stream_encoder #(.DATA_WIDTH(DW), .CODE_WIDTH(CW), .DICT_DEPTH(2), .FULL_MODE(0)) u2 (
        .clk(clk), .rst(rst[2]), .cs(cs[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_last(in_last[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_code(out_code[2]), .out_last(out_last[2]), .busy(busy[2]), .dict_count(dc2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] get_dc(input int k);
        case (k)
            0:       return {29'd0, dc0};
            1:       return {30'd0, dc1};
            default: return {30'd0, dc2};
        endcase
    endfunction

    // Reference: textbook LZW over a bounded table; dictionary is a pair of queues searched in order
    task automatic model(input int k);
        int depth;
        int fm;
        int w;
        int c;
        int hit;
        int pre [$];
        int sy  [$];
        depth = (k == 0) ? 4 : 2;
        fm    = (k == 1) ? 1 : 0;
        exp_c.delete();
        w = stim[0];
        for (int i = 1; i < stim.size(); i++) begin
            c   = stim[i];
            hit = -1;
            for (int j = 0; j < pre.size(); j++)
                if (hit < 0 && pre[j] == w && sy[j] == c) hit = j;
            if (hit >= 0) begin
                w = 257 + hit;
            end else begin
                exp_c.push_back(w);
                if (pre.size() < depth) begin
                    pre.push_back(w);
                    sy.push_back(c);
                end
                if (fm == 1 && pre.size() == depth) begin
                    exp_c.push_back(256);
                    pre.delete();
                    sy.delete();
                end
                w = c;
            end
        end
        exp_c.push_back(w);
        exp_n = pre.size();
    endtask

    // stall: 0 = always ready, >0 = fixed low cycles per code, <0 = random; stop_at >= 0 aborts after that many symbols
    task automatic run_stream(input int k, input int stall, input int stop_at, output bit to);
        int pos;
        int cnt;
        int hold_len;
        int budget;
        bit holding;
        bit done;
        logic [CW-1:0] held;
        pos = 0; cnt = 0; hold_len = 0; budget = 0; holding = 0; done = 0; held = '0; to = 0;
        got_c.delete();
        got_l.delete();
        @(negedge clk);
        cs[k] = 1'b1;
        @(negedge clk);
        cs[k] = 1'b0;
        while (!done) begin
            check("ready_valid_excl", {31'd0, in_ready[k] & out_valid[k]}, 0);
            if (in_ready[k] && pos < stim.size()) begin
                in_valid[k] = 1'b1;
                in_data[k]  = DW'(stim[pos]);
                in_last[k]  = (pos == stim.size() - 1);
                pos++;
            end else begin
                in_valid[k] = 1'b0;
                in_last[k]  = 1'b0;
            end
            if (out_valid[k]) begin
                if (!holding) begin
                    holding  = 1;
                    held     = out_code[k];
                    hold_len = (stall < 0) ? $urandom_range(0, 3) : stall;
                    cnt      = 0;
                end else begin
                    check("code_stable", {20'd0, out_code[k]}, {20'd0, held});
                end
                if (cnt < hold_len) begin
                    out_ready[k] = 1'b0;
                    cnt++;
                end else begin
                    out_ready[k] = 1'b1;
                    got_c.push_back(int'(out_code[k]));
                    got_l.push_back(int'(out_last[k]));
                    holding = 0;
                    if (out_last[k]) done = 1;
                end
            end else begin
                out_ready[k] = (stall == 0);
            end
            if (stop_at >= 0 && pos == stop_at && in_valid[k]) done = 1;
            @(negedge clk);
            budget++;
            if (!done && budget > 3000) begin
                to   = 1;
                done = 1;
            end
        end
        in_valid[k]  = 1'b0;
        in_last[k]   = 1'b0;
        out_ready[k] = 1'b0;
    endtask

    task automatic run_and_check(input int k, input int stall);
        bit to;
        model(k);
        run_stream(k, stall, -1, to);
        check("timeout", {31'd0, to}, 0);
        check("n_codes", got_c.size(), exp_c.size());
        for (int i = 0; i < exp_c.size() && i < got_c.size(); i++) begin
            check("code", got_c[i], exp_c[i]);
            check("last_flag", got_l[i], (i == exp_c.size() - 1) ? 1 : 0);
        end
        check("busy_end", {31'd0, busy[k]}, 0);
        check("dict_count_end", get_dc(k), exp_n);
    endtask

    task automatic check_lits(input string tag);
        check({tag, "_len"}, got_c.size(), lit.size());
        for (int i = 0; i < lit.size() && i < got_c.size(); i++)
            check(tag, got_c[i], lit[i]);
    endtask

    task automatic check_reset_state(input int k);
        check("rst_in_ready",   {31'd0, in_ready[k]}, 0);
        check("rst_out_valid",  {31'd0, out_valid[k]}, 0);
        check("rst_out_last",   {31'd0, out_last[k]}, 0);
        check("rst_out_code",   {20'd0, out_code[k]}, 0);
        check("rst_busy",       {31'd0, busy[k]}, 0);
        check("rst_dict_count", get_dc(k), 0);
    endtask

    initial begin
        bit to;
        int k;
        int len;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; cs[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = '0;
            in_last[i] = 1'b0; out_ready[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        for (int i = 0; i < 3; i++) check_reset_state(i);

        stim = '{'h41, 'h42, 'h41, 'h42, 'h41, 'h42, 'h41};
        run_and_check(0, 0);
        lit = '{'h041, 'h042, 'h101, 'h103};
        check_lits("ababa_codes");
        check("ababa_dict", get_dc(0), 3);

        stim = '{'h41, 'h42, 'h43, 'h44};
        run_and_check(1, 0);
        lit = '{'h041, 'h042, 'h100, 'h043, 'h044};
        check_lits("full_clear_codes");
        check("full_clear_dict", get_dc(1), 1);

        run_and_check(2, 0);
        lit = '{'h041, 'h042, 'h043, 'h044};
        check_lits("full_freeze_codes");
        check("full_freeze_dict", get_dc(2), 2);

        stim = '{'h7F};
        run_and_check(0, 0);
        lit = '{'h07F};
        check_lits("single_codes");

        stim = '{'h41, 'h42, 'h41, 'h42, 'h41, 'h42, 'h41};
        run_and_check(0, 5);
        lit = '{'h041, 'h042, 'h101, 'h103};
        check_lits("stall_codes");

        run_stream(0, 0, 3, to);
        check("abort_timeout", {31'd0, to}, 0);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check_reset_state(0);
        stim = '{'h41, 'h42};
        run_and_check(0, 0);
        lit = '{'h041, 'h042};
        check_lits("after_rst_codes");

        for (int t = 0; t < 30; t++) begin
            k   = $urandom_range(0, 2);
            len = $urandom_range(1, 20);
            stim.delete();
            for (int i = 0; i < len; i++)
                stim.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : 'h41 + $urandom_range(0, 2));
            run_and_check(k, ($urandom_range(0, 1) == 1) ? -1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
